gr8b0nd_data_responder: RTL and testbench

Word-addressed data-memory responder for the gr8b0nd multicycle processor: it services `ld`/`st` requests issued by the processor's execute state over a valid/ready request channel and returns results over a valid/ready response channel. It sits between the processor core and the data store, inserts a programmable number of wait states, and flags out-of-range accesses. It is the responder end of the core's memory-initiator interface.

---
 rtl/gr8b0nd_data_responder.sv | 118 +++++++++++
 tb/tb_gr8b0nd_data_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gr8b0nd_data_responder.sv
// Word-addressed data-memory responder for the gr8b0nd core: one outstanding ld/st,
// programmable wait states, out-of-range flagging and a completed-response counter.
module gr8b0nd_data_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] served_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [15:0] addr_q, wdata_q;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] served_q, served_d;
  logic        accept, commit, in_range;

  // Deliberately not reset: contents are undefined until written.
  logic [15:0] mem [DEPTH];

  assign in_range = 32'(addr_q) < DEPTH;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    served_d = served_q;
    accept   = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = StWait;
        end
      end
      StWait: begin
        // Commit edge lands LATENCY+1 edges after accept.
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = StResp;
          err_d   = ~in_range;
          if (!in_range) begin
            rdata_d = 16'h0000;
          end else if (we_q) begin
            rdata_d = wdata_q;
          end else begin
            rdata_d = mem[addr_q[AW-1:0]];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d  = StIdle;
          served_d = served_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      rdata_q  <= 16'h0000;
      err_q    <= 1'b0;
      served_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      served_q <= served_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && we_q && in_range) begin
      mem[addr_q[AW-1:0]] <= wdata_q;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign resp_valid   = (state_q == StResp);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign served_count = served_q;

endmodule

// File: tb/tb_gr8b0nd_data_responder.sv
// Randomized bench for gr8b0nd_data_responder against a transaction-level memory model.
module tb_gr8b0nd_data_responder;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] served_count;

  int checks = 0;
  int failures = 0;

  logic [15:0] model_mem [DEPTH];
  bit          model_known [DEPTH];
  logic [15:0] model_served = 16'h0000;

  gr8b0nd_data_responder #(
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .served_count(served_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full request/response; hold = cycles resp_ready stays low once the response shows.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                     input int hold);
    logic [15:0] exp_rdata;
    logic        exp_err;
    bit          data_known;
    int          lat;
    exp_err    = (32'(addr) >= DEPTH);
    data_known = 1'b1;
    if (exp_err) begin
      exp_rdata = 16'h0000;
    end else if (we) begin
      exp_rdata = wdata;
      model_mem[addr] = wdata;
      model_known[addr] = 1'b1;
    end else begin
      exp_rdata  = model_mem[addr];
      data_known = model_known[addr];
    end

    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    // Keep req_valid high with junk: must be ignored until back in idle.
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    if (hold == 0) resp_ready = 1'b1;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      check("req_ready_busy", 32'(req_ready), 32'd0);
      check("served_wait", 32'(served_count), 32'(model_served));
      step();
      lat++;
    end
    check("latency", lat, LATENCY + 1);
    check("resp_err", 32'(resp_err), 32'(exp_err));
    if (data_known) check("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_err", 32'(resp_err), 32'(exp_err));
      if (data_known) check("hold_rdata", 32'(resp_rdata), 32'(exp_rdata));
    end
    resp_ready = 1'b1;
    step();
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    model_served = model_served + 16'd1;
    check("resp_valid_done", 32'(resp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
    check("served_count", 32'(served_count), 32'(model_served));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, 32'(resp_rdata), 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_served"}, 32'(served_count), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    step();
    check_reset_outputs("reset");
    reset = 1'b1;
    step();

    // Store then load same address.
    txn(1'b1, 16'd5, 16'h1234, 0);
    txn(1'b0, 16'd5, 16'h0000, 0);
    check("served_two", 32'(served_count), 32'd2);

    // Out of range store must not alias onto addr 0.
    txn(1'b1, 16'd0, 16'h0001, 0);
    txn(1'b1, 16'd256, 16'h5555, 0);
    txn(1'b0, 16'd0, 16'h0000, 0);
    txn(1'b0, 16'hffff, 16'h0000, 1);

    // Backpressure with junk requests pending.
    txn(1'b1, 16'd9, 16'hbeef, 5);
    txn(1'b0, 16'd9, 16'h0000, 0);

    // Reset during WAIT of a store drops it.
    txn(1'b1, 16'd7, 16'h0007, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'd7;
    req_wdata = 16'haaaa;
    step();
    req_valid = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_served = 16'h0000;
    step();
    reset = 1'b1;
    step();
    txn(1'b0, 16'd7, 16'h0000, 0);
    check("served_after_reset", 32'(served_count), 32'd1);

    // Random mix.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(7) == 0) a = 16'($urandom_range(65535, DEPTH));
      else a = 16'($urandom_range(DEPTH - 1));
      txn(1'($urandom), a, 16'($urandom), int'($urandom_range(3)));
    end

    // Counter wrap.
    force dut.served_q = 16'hffff;
    #1;
    release dut.served_q;
    model_served = 16'hffff;
    check("served_preload", 32'(served_count), 32'hffff);
    txn(1'b0, 16'd5, 16'h0000, 0);
    check("served_wrap", 32'(served_count), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
